// File: rtl/pool2_ctrl_pkg.sv
// Shared FSM state type and per-channel geometry constants for the pool2 sequencer.
package pool2_ctrl_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StFeed,
        StDrain,
        StFin
    } state_e;

    localparam int unsigned PIX_PER_CH = 64;
    localparam int unsigned OUT_PER_CH = 16;

    localparam int unsigned PIX_W     = $clog2(PIX_PER_CH);
    localparam int unsigned OUT_W     = $clog2(OUT_PER_CH);
    localparam int unsigned CH_W      = 4;
    localparam int unsigned CH_PORT_W = 5;

endpackage

// File: rtl/pool2_ctrl_wr_stage.sv
// Result write register: forms the ch*16+k result address and registers the pooled value.
// Optional build macro POOL2_CTRL_RELU_EN: when defined, negative results are written as zero.
module pool2_ctrl_wr_stage
    import pool2_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned OUT_ADDR_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  accept,
    input  logic [CH_W-1:0]       ch,
    input  logic [OUT_W-1:0]      k,
    input  logic [DATA_W-1:0]     data,
    output logic                  res_wr_en,
    output logic [OUT_ADDR_W-1:0] res_wr_addr,
    output logic [DATA_W-1:0]     res_wr_data
);

    logic [DATA_W-1:0] data_d;

    always_comb begin
`ifdef POOL2_CTRL_RELU_EN
        data_d = data[DATA_W-1] ? '0 : data;
`else
        data_d = data;
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            res_wr_en   <= 1'b0;
            res_wr_addr <= '0;
            res_wr_data <= '0;
        end else begin
            res_wr_en <= accept;
            if (accept) begin
                res_wr_addr <= OUT_ADDR_W'({ch, k});
                res_wr_data <= data_d;
            end
        end
    end

endmodule

// File: rtl/pool2_ctrl.sv
// Sequencer for the second max-pool stage: feeds one channel of the conv2 map at a time into
// pool2 and collects its 16 results. Optional build macro POOL2_CTRL_RELU_EN (see write stage).
module pool2_ctrl
    import pool2_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned IMG_IN_W   = 8,
    parameter int unsigned CH_NUM     = 16,
    parameter int unsigned IN_ADDR_W  = 10,
    parameter int unsigned OUT_ADDR_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic                  fm_rd_en,
    output logic [IN_ADDR_W-1:0]  fm_rd_addr,
    input  logic [DATA_W-1:0]     fm_rd_data,
    output logic [DATA_W-1:0]     pool_data_in,
    output logic                  pool_data_in_valid,
    output logic [4:0]            pool_in_channel,
    input  logic [DATA_W-1:0]     pool_data_out,
    input  logic                  pool_data_out_valid,
    output logic                  res_wr_en,
    output logic [OUT_ADDR_W-1:0] res_wr_addr,
    output logic [DATA_W-1:0]     res_wr_data
);

    localparam int unsigned PixLast  = IMG_IN_W * IMG_IN_W - 1;
    localparam int unsigned OutPerCh = (IMG_IN_W / 2) * (IMG_IN_W / 2);

    localparam logic [PIX_W-1:0]     PixLastW = PIX_W'(PixLast);
    localparam logic [OUT_W:0]       CntFull  = (OUT_W + 1)'(OutPerCh);
    localparam logic [CH_PORT_W-1:0] ChLast   = CH_PORT_W'(CH_NUM - 1);

    state_e               state_q;
    logic [PIX_W-1:0]     pix_q;
    logic [OUT_W:0]       out_cnt_q;
    logic [CH_PORT_W-1:0] ch_q;
    logic                 in_pass;
    logic                 accept;

    assign in_pass = (state_q == StFeed) || (state_q == StDrain);
    assign accept  = pool_data_out_valid && in_pass && (out_cnt_q < CntFull);

    assign pool_data_in    = fm_rd_data;
    assign pool_in_channel = ch_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q            <= StIdle;
            pix_q              <= '0;
            out_cnt_q          <= '0;
            ch_q               <= '0;
            busy               <= 1'b0;
            done               <= 1'b0;
            err                <= 1'b0;
            fm_rd_en           <= 1'b0;
            fm_rd_addr         <= '0;
            pool_data_in_valid <= 1'b0;
        end else begin
            done               <= 1'b0;
            pool_data_in_valid <= fm_rd_en;
            if (accept) begin
                out_cnt_q <= out_cnt_q + 1'b1;
            end else if (pool_data_out_valid) begin
                err <= 1'b1;
            end

            case (state_q)
                StIdle: begin
                    if (start) begin
                        state_q    <= StFeed;
                        busy       <= 1'b1;
                        fm_rd_en   <= 1'b1;
                        fm_rd_addr <= '0;
                        ch_q       <= '0;
                        pix_q      <= '0;
                        out_cnt_q  <= '0;
                        // A stray result arriving alongside start is still flagged.
                        err        <= pool_data_out_valid;
                    end
                end
                StFeed: begin
                    if (pix_q == PixLastW) begin
                        fm_rd_en <= 1'b0;
                        state_q  <= StDrain;
                    end else begin
                        pix_q      <= pix_q + 1'b1;
                        fm_rd_addr <= fm_rd_addr + 1'b1;
                    end
                end
                StDrain: begin
                    if (out_cnt_q == CntFull) begin
                        if (ch_q == ChLast) begin
                            state_q <= StFin;
                        end else begin
                            state_q    <= StFeed;
                            ch_q       <= ch_q + 1'b1;
                            pix_q      <= '0;
                            out_cnt_q  <= '0;
                            fm_rd_en   <= 1'b1;
                            fm_rd_addr <= fm_rd_addr + 1'b1;
                        end
                    end
                end
                StFin: begin
                    busy    <= 1'b0;
                    done    <= 1'b1;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    pool2_ctrl_wr_stage #(
        .DATA_W     (DATA_W),
        .OUT_ADDR_W (OUT_ADDR_W)
    ) u_wr_stage (
        .clk         (clk),
        .rst_n       (rst_n),
        .accept      (accept),
        .ch          (ch_q[CH_W-1:0]),
        .k           (out_cnt_q[OUT_W-1:0]),
        .data        (pool_data_out),
        .res_wr_en   (res_wr_en),
        .res_wr_addr (res_wr_addr),
        .res_wr_data (res_wr_data)
    );

endmodule

// File: tb/tb_pool2_ctrl.sv
// Randomized bench for pool2_ctrl: RAM and pool2 stand-ins plus an array-based reference of the
// expected 2x2 maxima. Honours POOL2_CTRL_RELU_EN when computing expected results.
module tb_pool2_ctrl;

    localparam int unsigned DATA_W     = 16;
    localparam int unsigned IN_ADDR_W  = 10;
    localparam int unsigned OUT_ADDR_W = 8;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  start = 1'b0;
    logic                  busy, done, err;
    logic                  fm_rd_en;
    logic [IN_ADDR_W-1:0]  fm_rd_addr;
    logic [DATA_W-1:0]     fm_rd_data = '0;
    logic [DATA_W-1:0]     pool_data_in;
    logic                  pool_data_in_valid;
    logic [4:0]            pool_in_channel;
    logic [DATA_W-1:0]     pool_data_out = '0;
    logic                  pool_data_out_valid = 1'b0;
    logic                  res_wr_en;
    logic [OUT_ADDR_W-1:0] res_wr_addr;
    logic [DATA_W-1:0]     res_wr_data;

    always #5 clk = ~clk;

    pool2_ctrl #(
        .DATA_W     (DATA_W),
        .IMG_IN_W   (8),
        .CH_NUM     (16),
        .IN_ADDR_W  (IN_ADDR_W),
        .OUT_ADDR_W (OUT_ADDR_W)
    ) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .start               (start),
        .busy                (busy),
        .done                (done),
        .err                 (err),
        .fm_rd_en            (fm_rd_en),
        .fm_rd_addr          (fm_rd_addr),
        .fm_rd_data          (fm_rd_data),
        .pool_data_in        (pool_data_in),
        .pool_data_in_valid  (pool_data_in_valid),
        .pool_in_channel     (pool_in_channel),
        .pool_data_out       (pool_data_out),
        .pool_data_out_valid (pool_data_out_valid),
        .res_wr_en           (res_wr_en),
        .res_wr_addr         (res_wr_addr),
        .res_wr_data         (res_wr_data)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Feature map contents and reference results
    logic [15:0] fm [1024];
    logic [15:0] res_mem [256];
    int          res_pass [256];
    int          pass_id = 0;

    function automatic logic [15:0] ref_res(input int a);
        int ch   = a / 16;
        int k    = a % 16;
        int base = ch * 64 + (k / 4) * 16 + (k % 4) * 2;
        logic signed [15:0] m = fm[base];
        for (int dy = 0; dy < 2; dy++) begin
            for (int dx = 0; dx < 2; dx++) begin
                if ($signed(fm[base + dy * 8 + dx]) > m) m = fm[base + dy * 8 + dx];
            end
        end
`ifdef POOL2_CTRL_RELU_EN
        if (m < 0) m = '0;
`endif
        return m;
    endfunction

    // Environment model: feature-map RAM, pool2 stand-in, result RAM and monitors
    logic [15:0] q_data [$];
    logic [15:0] win [64];
    int          pix_idx = 0;
    int          rd_cnt = 0, done_cnt = 0, wr_cnt = 0, ch_steps = 0, hold_viol = 0;
    int          chan_wr [16];
    int          prev_ch = 0;
    int          inj_req = 0, inj_seen = 0;
    logic [15:0] inj_data = '0;
    logic        rd_s = 1'b0;
    logic [IN_ADDR_W-1:0] rd_addr_s = '0;

    initial begin : env_model
        logic signed [15:0] m;
        for (int i = 0; i < 16; i++) chan_wr[i] = 0;
        for (int i = 0; i < 256; i++) res_pass[i] = -1;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                q_data.delete();
                pix_idx = 0;
                prev_ch = int'(pool_in_channel);
            end else begin
                if (fm_rd_en) rd_cnt++;
                if (done) done_cnt++;
                if (!busy) for (int i = 0; i < 16; i++) chan_wr[i] = 0;
                if (res_wr_en) begin
                    res_mem[res_wr_addr]  = res_wr_data;
                    res_pass[res_wr_addr] = pass_id;
                    wr_cnt++;
                    chan_wr[res_wr_addr[7:4]]++;
                end
                if (int'(pool_in_channel) != prev_ch) begin
                    if (pool_in_channel != 5'd0) begin
                        ch_steps++;
                        if (int'(pool_in_channel) != prev_ch + 1 || pool_data_in_valid ||
                            q_data.size() != 0 || chan_wr[prev_ch] != 16) hold_viol++;
                    end
                    prev_ch = int'(pool_in_channel);
                end
                if (pool_data_in_valid) begin
                    win[pix_idx] = pool_data_in;
                    if (pix_idx[0] && pix_idx[3]) begin
                        m = win[pix_idx];
                        if ($signed(win[pix_idx - 1]) > m) m = win[pix_idx - 1];
                        if ($signed(win[pix_idx - 8]) > m) m = win[pix_idx - 8];
                        if ($signed(win[pix_idx - 9]) > m) m = win[pix_idx - 9];
                        q_data.push_back(m);
                    end
                    pix_idx = (pix_idx + 1) % 64;
                end
            end
            rd_s      = fm_rd_en;
            rd_addr_s = fm_rd_addr;
            @(posedge clk);
            #1;
            if (rd_s) fm_rd_data = fm[rd_addr_s];
            pool_data_out_valid = 1'b0;
            if (rst_n) begin
                if (inj_req != inj_seen) begin
                    inj_seen++;
                    pool_data_out_valid = 1'b1;
                    pool_data_out       = inj_data;
                end else if (q_data.size() != 0 && $urandom_range(2) != 0) begin
                    pool_data_out_valid = 1'b1;
                    pool_data_out       = q_data.pop_front();
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_err"}, err, 0);
        check({tag, "_rd_en"}, fm_rd_en, 0);
        check({tag, "_rd_addr"}, fm_rd_addr, 0);
        check({tag, "_in_valid"}, pool_data_in_valid, 0);
        check({tag, "_in_channel"}, pool_in_channel, 0);
        check({tag, "_wr_en"}, res_wr_en, 0);
        check({tag, "_wr_addr"}, res_wr_addr, 0);
        check({tag, "_wr_data"}, res_wr_data, 0);
    endtask

    task automatic wait_done(input string name);
        bit seen = 0;
        for (int c = 0; c < 4000 && !seen; c++) begin
            step();
            if (done) seen = 1;
        end
        check({name, "_done_seen"}, seen, 1);
        check({name, "_busy_at_done"}, busy, 0);
        step();
        check({name, "_done_one_cycle"}, done, 0);
        step();
        step();
    endtask

    task automatic check_results(input string name, input int rd0, input int dn0, input int wr0,
                                 input int st0);
        int n = 0;
        check({name, "_rd_count"}, rd_cnt - rd0, 1024);
        check({name, "_done_count"}, done_cnt - dn0, 1);
        check({name, "_wr_count"}, wr_cnt - wr0, 256);
        check({name, "_ch_steps"}, ch_steps - st0, 15);
        for (int a = 0; a < 256; a++) begin
            if (res_pass[a] != pass_id || res_mem[a] !== ref_res(a)) n++;
        end
        check({name, "_result_mismatches"}, n, 0);
    endtask

    task automatic run_pass(input string name, input bit mid_start);
        int rd0 = rd_cnt;
        int dn0 = done_cnt;
        int wr0 = wr_cnt;
        int st0 = ch_steps;
        pass_id++;
        pulse_start();
        check({name, "_busy_t1"}, busy, 1);
        check({name, "_rd_en_t1"}, fm_rd_en, 1);
        check({name, "_in_valid_t1"}, pool_data_in_valid, 0);
        check({name, "_err_cleared"}, err, 0);
        step();
        check({name, "_in_valid_t2"}, pool_data_in_valid, 1);
        if (mid_start) begin
            repeat (98) step();
            pulse_start();
            check({name, "_busy_mid"}, busy, 1);
        end
        wait_done(name);
        check_results(name, rd0, dn0, wr0, st0);
    endtask

    initial begin : main
        int wr0, dn0, rd0, st0;
        bit found;

        repeat (3) step();
        check_all_zero("reset");
        rst_n = 1'b1;
        step();
        check_all_zero("idle");

        for (int i = 0; i < 1024; i++) fm[i] = 16'(i);
        run_pass("ramp", 1'b0);
        check("ramp_addr0", res_mem[0], 16'd9);
        check("ramp_addr16", res_mem[16], 16'd73);

        for (int i = 0; i < 1024; i++) fm[i] = 16'hFC00 + 16'(i);
        run_pass("neg", 1'b0);
`ifdef POOL2_CTRL_RELU_EN
        check("neg_addr5", res_mem[5], 16'h0000);
`else
        check("neg_addr5", res_mem[5], 16'hFC1B);
`endif

        wr0      = wr_cnt;
        inj_data = 16'h1234;
        inj_req++;
        step();
        step();
        check("inj_err_set", err, 1);
        check("inj_no_write", res_wr_en, 0);
        step();
        step();
        check("inj_err_sticky", err, 1);
        check("inj_wr_count", wr_cnt - wr0, 0);

        for (int i = 0; i < 1024; i++) fm[i] = 16'($urandom);
        run_pass("rand_mid_start", 1'b1);

        for (int i = 0; i < 1024; i++) fm[i] = 16'($urandom);
        dn0 = done_cnt;
        wr0 = wr_cnt;
        pulse_start();
        found = 0;
        for (int c = 0; c < 3000 && !found; c++) begin
            step();
            if (pool_in_channel == 5'd7 && fm_rd_en) found = 1;
        end
        check("abort_reached_ch7", found, 1);
        repeat (3) step();
        rst_n = 1'b0;
        step();
        check_all_zero("abort");
        step();
        rst_n = 1'b1;
        repeat (3) step();
        check("abort_no_done", done_cnt - dn0, 0);
        check("abort_busy_low", busy, 0);
        check("abort_writes_lt_256", (wr_cnt - wr0) < 256, 1);

        rd0 = rd_cnt;
        st0 = ch_steps;
        run_pass("after_abort", 1'b0);
        check("after_abort_total_rd", rd_cnt - rd0, 1024);
        check("ch_steps_total", ch_steps - st0, 15);
        check("channel_hold_violations", hold_viol, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
